// File: rtl/genius_jogo_param.sv
// Genius memory-sequence game core: LFSR-built sequence, LED playback and
// per-move checking with timeout. Control FSM and datapath share this module.
module genius_jogo_param #(
  parameter int          N_BOTOES       = 4,
  parameter int          N_RODADAS      = 16,
  parameter int          TIMEOUT_CICLOS = 5000,
  parameter int          LED_CICLOS     = 1000,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int         IW             = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1,
  localparam int         RW             = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                db_timeout,
  output logic [RW-1:0]       db_rodada,
  output logic [IW-1:0]       db_jogada,
  output logic [IW-1:0]       db_memoria,
  output logic [3:0]          db_estado
);

  localparam int TMAX = (TIMEOUT_CICLOS > LED_CICLOS) ? TIMEOUT_CICLOS : LED_CICLOS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_INICIAL    = 4'd0,
    S_PREPARA    = 4'd1,
    S_MOSTRA     = 4'd2,
    S_ESPERA     = 4'd3,
    S_REGISTRA   = 4'd4,
    S_COMPARA    = 4'd5,
    S_FIM_RODADA = 4'd6,
    S_ACERTOU    = 4'd10,
    S_TIMEOUT    = 4'd13,
    S_ERROU      = 4'd14
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [RW-1:0]       rodada_q, rodada_d;
  logic [RW-1:0]       end_q, end_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                aceso_q, aceso_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [N_BOTOES-1:0] bot_q, bot_d;
  logic [N_BOTOES-1:0] leds_q, leds_d;
  logic [IW-1:0]       jogada_q, jogada_d;
  logic                invalida_q, invalida_d;
  logic                pronto_q, pronto_d;
  logic                ganhou_q, ganhou_d;
  logic                perdeu_q, perdeu_d;
  logic                timeout_q, timeout_d;

  logic [IW-1:0] seq_mem [N_RODADAS];
  logic          mem_we;
  logic [RW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;
  logic [IW-1:0] elem_mostra;
  logic [IW-1:0] idx_botao;
  logic [15:0]   lfsr_prox;
  logic          jogada;
  logic          um_quente;

  assign jogada    = (botoes != '0) && (bot_q == '0);
  assign um_quente = (botoes != '0) && ((botoes & (botoes - N_BOTOES'(1))) == '0);
  assign lfsr_prox = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    idx_botao = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (botoes[i]) idx_botao = IW'(i);
    end
  end

  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    end_d      = end_q;
    timer_d    = timer_q;
    aceso_d    = aceso_q;
    lfsr_d     = lfsr_q;
    bot_d      = botoes;
    jogada_d   = jogada_q;
    invalida_d = invalida_q;
    mem_we     = 1'b0;
    mem_waddr  = rodada_q;
    mem_wdata  = lfsr_q[IW-1:0];
    leds_d     = '0;

    unique case (estado_q)
      S_INICIAL: if (iniciar) estado_d = S_PREPARA;
      S_PREPARA: begin
        rodada_d  = '0;
        end_d     = '0;
        timer_d   = '0;
        aceso_d   = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = '0;
        lfsr_d    = lfsr_prox;
        estado_d  = S_MOSTRA;
      end
      S_MOSTRA: begin
        // each element: LED_CICLOS lit, then LED_CICLOS dark
        if (timer_q == TW'(LED_CICLOS - 1)) begin
          timer_d = '0;
          if (aceso_q) begin
            aceso_d = 1'b0;
          end else if (end_q == rodada_q) begin
            end_d    = '0;
            estado_d = S_ESPERA;
          end else begin
            end_d   = end_q + RW'(1);
            aceso_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ESPERA: begin
        if (jogada) begin
          jogada_d   = idx_botao;
          invalida_d = !um_quente;
          estado_d   = S_REGISTRA;
        end else if (timer_q == TW'(TIMEOUT_CICLOS - 1)) begin
          estado_d = S_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_REGISTRA: estado_d = S_COMPARA;
      S_COMPARA: begin
        if (invalida_q || (jogada_q != seq_mem[end_q])) begin
          estado_d = S_ERROU;
        end else if (end_q == rodada_q) begin
          estado_d = S_FIM_RODADA;
        end else begin
          end_d    = end_q + RW'(1);
          timer_d  = '0;
          estado_d = S_ESPERA;
        end
      end
      S_FIM_RODADA: begin
        if (rodada_q == RW'(N_RODADAS - 1)) begin
          estado_d = S_ACERTOU;
        end else begin
          rodada_d  = rodada_q + RW'(1);
          end_d     = '0;
          timer_d   = '0;
          aceso_d   = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = rodada_q + RW'(1);
          lfsr_d    = lfsr_prox;
          estado_d  = S_MOSTRA;
        end
      end
      S_ACERTOU, S_ERROU, S_TIMEOUT: if (iniciar) estado_d = S_PREPARA;
      default: estado_d = S_INICIAL;
    endcase

    // Outputs are registered from the next state; bypass the element being written.
    elem_mostra = (mem_we && (mem_waddr == end_d)) ? mem_wdata : seq_mem[end_d];
    if ((estado_d == S_MOSTRA) && aceso_d) leds_d = N_BOTOES'(1) << elem_mostra;
    else if (estado_d == S_REGISTRA)       leds_d = botoes;
    else if (estado_d == S_COMPARA)        leds_d = leds_q;

    ganhou_d  = (estado_d == S_ACERTOU);
    timeout_d = (estado_d == S_TIMEOUT);
    perdeu_d  = (estado_d == S_ERROU) || (estado_d == S_TIMEOUT);
    pronto_d  = ganhou_d || perdeu_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= S_INICIAL;
      rodada_q   <= '0;
      end_q      <= '0;
      timer_q    <= '0;
      aceso_q    <= 1'b0;
      lfsr_q     <= SEED;
      bot_q      <= '0;
      leds_q     <= '0;
      jogada_q   <= '0;
      invalida_q <= 1'b0;
      pronto_q   <= 1'b0;
      ganhou_q   <= 1'b0;
      perdeu_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      rodada_q   <= rodada_d;
      end_q      <= end_d;
      timer_q    <= timer_d;
      aceso_q    <= aceso_d;
      lfsr_q     <= lfsr_d;
      bot_q      <= bot_d;
      leds_q     <= leds_d;
      jogada_q   <= jogada_d;
      invalida_q <= invalida_d;
      pronto_q   <= pronto_d;
      ganhou_q   <= ganhou_d;
      perdeu_q   <= perdeu_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) seq_mem[mem_waddr] <= mem_wdata;
  end

  assign leds       = leds_q;
  assign pronto     = pronto_q;
  assign ganhou     = ganhou_q;
  assign perdeu     = perdeu_q;
  assign db_timeout = timeout_q;
  assign db_rodada  = rodada_q;
  assign db_jogada  = jogada_q;
  assign db_memoria = seq_mem[end_q];
  assign db_estado  = estado_q;

endmodule

// File: doc/genius_jogo_param.md
Name: genius_jogo_param

Overview:
Parametrised memory-sequence ("Genius") game core: one-hot button inputs, N_BOTOES LEDs, and a self-generated sequence of up to N_RODADAS rounds.
- Each round appends one pseudo-random element, replays the whole sequence on the LEDs, then checks the player's inputs against it with a per-move timeout.
- Successor to the fixed 4-button/16-round game top, adding:
  - sequence generation;
  - LED playback;
  - invalid-press detection;
  - width, depth and timing generics.
- Control FSM and datapath live in one module; debug outputs go to the existing hexa7seg displays.

Parameters:
N_BOTOES, 4, number of buttons/LEDs; power of two, 2..16; IW = clog2(N_BOTOES)
N_RODADAS, 16, rounds to win; 2..256; RW = clog2(N_RODADAS)
TIMEOUT_CICLOS, 5000, cycles allowed per move before loss
LED_CICLOS, 1000, cycles each element is lit during playback (followed by an equal dark gap)
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start/restart request, level, sampled in INICIAL/ACERTOU/ERROU/TIMEOUT
botoes  in  N_BOTOES  player buttons, one-hot when valid, synchronous to clock
leds  out  N_BOTOES  one-hot playback/feedback, else 0
pronto  out  1  1 in ACERTOU, ERROU, TIMEOUT states
ganhou  out  1  1 in ACERTOU
perdeu  out  1  1 in ERROU or TIMEOUT
db_timeout  out  1  1 in TIMEOUT
db_rodada  out  RW  current round index (0-based)
db_jogada  out  IW  index of last registered press
db_memoria  out  IW  sequence element at current read address
db_estado  out  4  FSM state code

Behaviour:
- Reset (reset=0, asynchronous):
  - state INICIAL; all outputs 0; counters 0; LFSR = SEED; sequence RAM contents don't-care.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Steps only when an element is written.
  - Element = lfsr[IW-1:0] taken before the step.
- Sequence RAM: N_RODADAS x IW, synchronous write, combinational read at address end.
- Press detection:
  - botoes registered once (bot_q).
  - jogada = (botoes != 0) && (bot_q == 0): one cycle per press, rising edge of "any pressed".
  - Holding a button does not repeat.
  - db_jogada = binary index of botoes when one-hot.
  - A non-one-hot press sets flag invalida.
- FSM states and codes:
  - INICIAL 0: iniciar=1 -> PREPARA.
  - PREPARA 1: rodada=0, end=0, timer=0; write element to RAM[0], step LFSR -> MOSTRA.
  - MOSTRA 2: leds = onehot(RAM[end]) for LED_CICLOS cycles, then 0 for LED_CICLOS cycles. Then:
    - if end==rodada -> ESPERA with end=0, timer=0;
    - else end+1, stay.
  - ESPERA 3:
    - jogada -> REGISTRA.
    - Otherwise timer+1; timer==TIMEOUT_CICLOS-1 -> TIMEOUT.
  - REGISTRA 4: latch press index -> COMPARA. leds echo the pressed button while in REGISTRA/COMPARA.
  - COMPARA 5:
    - invalida or index!=RAM[end] -> ERROU;
    - else if end==rodada -> FIM_RODADA;
    - else end+1, timer=0 -> ESPERA.
  - FIM_RODADA 6:
    - rodada==N_RODADAS-1 -> ACERTOU;
    - else rodada+1, end=0, write element to RAM[rodada+1], step LFSR -> MOSTRA.
  - ACERTOU 10, ERROU 14, TIMEOUT 13:
    - hold outputs;
    - iniciar=1 -> PREPARA. The LFSR is NOT reset, so a replay gives a new sequence.
- Timing and precedence:
  - Timer resets on every entry to ESPERA.
  - A press in the same cycle the timer expires wins (goes to REGISTRA).
  - Presses outside ESPERA are ignored but update bot_q, so a button held into ESPERA does not count until released and re-pressed.
  - iniciar is ignored in all states except INICIAL and the three terminal states.
- Asynchronous reset mid-game: returns to INICIAL immediately, leds=0 the same instant.

Test Plan:
- Reset, defaults, SEED=16'hACE1, N_BOTOES=4 → after iniciar pulse:
  - first element = 1 (ACE1[1:0]);
  - leds=4'b0010 for exactly LED_CICLOS cycles, then 0 for LED_CICLOS cycles;
  - then db_estado=3.
- Full win, N_RODADAS=4, TIMEOUT_CICLOS=50, LED_CICLOS=4: model-driven correct presses each round → playback length grows 1,2,3,4; final ganhou=1, pronto=1, db_estado=10, db_rodada=3.
- Wrong press in round 2, move 1 → perdeu=1, db_estado=14, ganhou=0; then iniciar → db_estado=1, and the new first element matches model LFSR continuation.
- No press for 50 cycles in ESPERA → db_timeout=1, perdeu=1, db_estado=13 at cycle 50; a press on cycle 49 instead → REGISTRA.
- botoes=4'b0101 (two buttons) on a correct-index cycle → ERROU. Correct button held across the ESPERA entry → no jogada until release and re-press.
- reset=0 asserted during MOSTRA with leds nonzero → leds=0, all flags 0, db_estado=0 without a clock edge; LFSR returns to SEED (next game repeats first element 1).
